encoder_8x3_seq: RTL and testbench
==================================

Name: encoder_8x3_seq

Overview:
- Registered 8-to-3 priority encoder. It is the encode-side counterpart of the 3x8 decoder in the decoder family.
- It latches request lines into a pending register and presents the index of the highest-priority pending request on a valid/ready output.
- It clears each request once that request is handed off.
- It sits between request sources (interrupt/event lines) and a consumer that turns the code back into one-hot through decoder_3x8.

Parameters:
- N, 8, number of request lines.
- W, 3, code width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  active-low enable (0 = enabled), same polarity as the decoder family.
- req  input  N  request pulses or levels, sampled every clk edge.
- code  output  W  index of the presented request.
- code_valid  output  1  code holds a valid index.
- code_ready  input  1  consumer accepts code when code_valid and code_ready are both 1 at an edge.
- pending  output  N  requests latched but not yet presented.
- any_pending  output  1  OR-reduction of pending.
- dup  output  1  one-cycle pulse: a req bit arrived while the same pending bit was already set.

Behaviour:
- Reset (rst=1 at an edge): pending=0, code=0, code_valid=0, dup=0. Reset overrides everything, including mid-handshake; the presented code is discarded.
- Gated request: greq = req when en=0; greq = 0 when en=1.
- Candidate set: cand = pending | greq.
- Priority: the highest index wins (bit 7 is highest priority). enc(cand) returns the index of the most significant set bit.
- Slot free condition: slot_free = !code_valid | code_ready.
- Load, at an edge where slot_free and en=0 and cand!=0:
  - code <= enc(cand), code_valid <= 1.
  - pending <= cand with bit enc(cand) cleared.
- At an edge where slot_free and no load occurs: code_valid <= 0, code holds its last value, pending <= cand.
- Hold: while code_valid=1 and code_ready=0, code and code_valid are stable; pending <= cand.
- Latency: a req sampled at edge t, with a free slot and no higher-priority candidate, gives code_valid=1 after edge t (one cycle).
- Back-to-back: with code_ready held at 1, one code is issued per cycle in descending index order.
- Re-request of the presented index: the bit was already cleared at load, so it re-pends as a new request and dup is not asserted.
- dup <= |(greq & pending) at each edge. Merged duplicates are not counted.
- Disabled (en=1):
  - New req is ignored and pending is retained.
  - An in-flight code completes its handshake normally.
  - No new loads occur; after acceptance, code_valid=0.
- Re-enable: loading resumes at the first edge with en=0.
- Simultaneous events:
  - Acceptance and load in the same edge is legal: the next code is issued without a bubble.
  - req and load of the same bit in the same edge: that bit is presented, not left pending.
- any_pending is combinational from the pending register.
- enc is never evaluated as valid when cand=0.

Decomposition:
- Shared package encoder_pkg:
  - constants N=8, W=3.
  - function prio_enc(N-bit) returning W-bit MSB-first index.
  - localparam ZERO_CODE.
- Sub-module prio_enc_8x3 (purely combinational: in[7:0] -> idx[2:0], nz) is natural and is also reusable by the 3x8 decoder bench as a checker.
- The top level holds the pending register, the output slot and the handshake.

Test Plan:
- Reset then single request: rst=1 for 2 cycles, then en=0, code_ready=1, req=8'h08 for 1 cycle -> code=3, code_valid=1 after that edge; pending=0; code_valid=0 next cycle.
- Priority drain: req=8'hA5 for 1 cycle, code_ready=1 -> codes 7,5,2,0 on consecutive cycles; pending goes A5 -> 25 -> 05 -> 01 -> 00 (after each load: 25,05,01,00).
- Backpressure: req=8'h81, code_ready=0 for 5 cycles -> code=7 stable, pending=8'h01; then code_ready=1 -> code=0 next cycle, then code_valid=0.
- Duplicate: code_ready=0, req=8'h10 at t then again at t+2 while bit 4 is still pending -> dup=1 for exactly one cycle after t+2; bit 4 is issued once.
- Disable: en=1, req=8'hFF -> pending stays 0 and code_valid stays 0; with an in-flight code=6, code_ready=1 completes it and then code_valid=0.
- Reset mid-operation: pending=8'h3C, code_valid=1, assert rst -> all outputs 0 after that edge, and no stale code after rst is released.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the registered 8x3 priority encoder.
// Highest set bit wins; an all-zero input yields index 0.
package encoder_pkg;

  localparam int N = 8;
  localparam int W = 3;

  localparam logic [W-1:0] ZERO_CODE = '0;

  function automatic logic [W-1:0] prio_enc(
    input logic [N-1:0] vec
  );
    logic [W-1:0] idx;
    idx = ZERO_CODE;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = i[W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational MSB-first 8-to-3 priority encoder.
// nz flags that idx refers to a real set bit.
module prio_enc_8x3
  import encoder_pkg::*;
(
  input  logic [N-1:0] in,
  output logic [W-1:0] idx,
  output logic         nz
);

  assign idx = prio_enc(in);
  assign nz  = |in;

endmodule

// File: rtl/encoder_8x3_seq.sv
// Registered priority encoder: latches requests, presents the highest
// pending index over valid/ready, and retires it at load time.
module encoder_8x3_seq
  import encoder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic [N-1:0] pending,
  output logic         any_pending,
  output logic         dup
);

  logic [N-1:0] greq;
  logic [N-1:0] cand;
  logic [N-1:0] sel;
  logic [W-1:0] idx;
  logic         nz;
  logic         slot_free;
  logic         load;

  assign greq      = en ? '0 : req;
  assign cand      = pending | greq;
  assign slot_free = !code_valid || code_ready;
  assign load      = slot_free && !en && nz;

  prio_enc_8x3 u_enc (
    .in  (cand),
    .idx (idx),
    .nz  (nz)
  );

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

  // The loaded bit leaves pending now, so a re-request re-pends cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      code       <= ZERO_CODE;
      code_valid <= 1'b0;
      dup        <= 1'b0;
    end else begin
      dup <= |(greq & pending);
      if (load) begin
        code       <= idx;
        code_valid <= 1'b1;
        pending    <= cand & ~sel;
      end else begin
        pending <= cand;
        if (slot_free) code_valid <= 1'b0;
      end
    end
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Scoreboard bench for encoder_8x3_seq with directed vectors.
// A negedge monitor retires expected codes on each accepted handshake.
module tb_encoder_8x3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] pending;
  logic       any_pending;
  logic       dup;

  int checks = 0;
  int errors = 0;
  logic [2:0] expq[$];

  always #5 clk = ~clk;

  encoder_8x3_seq dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .pending     (pending),
    .any_pending (any_pending),
    .dup         (dup)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs change 1ns after posedge, so negedge sees the next edge's view.
  always @(negedge clk) begin
    if (!rst && code_valid && code_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_code: got %0d expected none", code);
      end else begin
        chk("code", 32'(code), 32'(expq.pop_front()));
      end
    end
  end

  logic [7:0] drain [4] = '{8'h25, 8'h05, 8'h01, 8'h00};

  initial begin
    rst = 1'b1; en = 1'b1; req = '0; code_ready = 1'b0;
    cyc(); cyc();
    chk("rst_pending", 32'(pending), 0);
    chk("rst_valid", 32'(code_valid), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_dup", 32'(dup), 0);
    chk("rst_any", 32'(any_pending), 0);

    // single request
    rst = 1'b0; en = 1'b0; code_ready = 1'b1; req = 8'h08;
    expq.push_back(3'd3);
    cyc();
    chk("single_valid", 32'(code_valid), 1);
    chk("single_pending", 32'(pending), 0);
    req = '0;
    cyc();
    chk("single_idle", 32'(code_valid), 0);

    // priority drain
    req = 8'hA5;
    expq.push_back(3'd7); expq.push_back(3'd5);
    expq.push_back(3'd2); expq.push_back(3'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      req = '0;
      chk("drain_valid", 32'(code_valid), 1);
      chk("drain_pending", 32'(pending), 32'(drain[i]));
    end
    cyc();
    chk("drain_idle", 32'(code_valid), 0);

    // backpressure
    code_ready = 1'b0; req = 8'h81;
    expq.push_back(3'd7); expq.push_back(3'd0);
    cyc();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_code", 32'(code), 7);
      chk("bp_valid", 32'(code_valid), 1);
      chk("bp_pending", 32'(pending), 32'h01);
      if (i < 4) cyc();
    end
    code_ready = 1'b1;
    cyc();
    chk("bp_next_code", 32'(code), 0);
    chk("bp_next_valid", 32'(code_valid), 1);
    chk("bp_next_pending", 32'(pending), 0);
    cyc();
    chk("bp_idle", 32'(code_valid), 0);

    // duplicate while slot is occupied
    code_ready = 1'b0; req = 8'h80;
    expq.push_back(3'd7);
    cyc();
    req = 8'h10;
    cyc();
    chk("dup_t", 32'(dup), 0);
    chk("dup_pend", 32'(pending), 32'h10);
    req = '0;
    cyc();
    chk("dup_t1", 32'(dup), 0);
    req = 8'h10;
    cyc();
    chk("dup_t2", 32'(dup), 1);
    chk("dup_pend2", 32'(pending), 32'h10);
    req = '0;
    cyc();
    chk("dup_t3", 32'(dup), 0);
    code_ready = 1'b1;
    expq.push_back(3'd4);
    cyc();
    chk("dup_issue", 32'(code_valid), 1);
    chk("dup_cleared", 32'(pending), 0);
    cyc();
    chk("dup_idle", 32'(code_valid), 0);

    // disabled
    en = 1'b1; req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dis_pending", 32'(pending), 0);
      chk("dis_valid", 32'(code_valid), 0);
    end
    en = 1'b0; code_ready = 1'b0; req = 8'h40;
    expq.push_back(3'd6);
    cyc();
    chk("dis_inflight", 32'(code_valid), 1);
    en = 1'b1; req = 8'hFF; code_ready = 1'b1;
    cyc();
    chk("dis_done_valid", 32'(code_valid), 0);
    chk("dis_done_pend", 32'(pending), 0);
    en = 1'b0; req = '0;

    // reset mid-operation, presented code is discarded
    code_ready = 1'b0; req = 8'hBC;
    cyc();
    req = '0;
    chk("mid_valid", 32'(code_valid), 1);
    chk("mid_pending", 32'(pending), 32'h3C);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", 32'(code_valid), 0);
    chk("mid_rst_pend", 32'(pending), 0);
    chk("mid_rst_code", 32'(code), 0);
    chk("mid_rst_any", 32'(any_pending), 0);
    rst = 1'b0; code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_valid", 32'(code_valid), 0);
      chk("post_rst_pend", 32'(pending), 0);
    end

    chk("queue_empty", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
